// File: rtl/hvac_dwell_controller.sv
// Cooler/heater sequencer with hysteresis, minimum on-time, dead-time and fire-alarm override.
// Optional run-time limit with sticky fault is enabled by defining HVAC_TIMEOUT_EN.
module hvac_dwell_controller #(
    parameter logic [7:0] COOL_ON  = 8'd30,
    parameter logic [7:0] COOL_OFF = 8'd27,
    parameter logic [7:0] HEAT_ON  = 8'd18,
    parameter logic [7:0] HEAT_OFF = 8'd21,
    parameter int         MIN_ON   = 1000,
    parameter int         DEAD     = 500,
    parameter int         MAX_RUN  = 60000,
    parameter int         CNT_W    = 16
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic [7:0] ST,
    input  logic       SFA,
    output logic       cooler,
    output logic       heater,
    output logic [1:0] hvac_state,
    output logic       dwell_busy,
    output logic       fault
);

    localparam logic [1:0] S_OFF  = 2'b00;
    localparam logic [1:0] S_COOL = 2'b01;
    localparam logic [1:0] S_HEAT = 2'b10;
    localparam logic [1:0] S_REST = 2'b11;

    localparam logic [CNT_W-1:0] MIN_ON_M1 = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] DEAD_M1   = CNT_W'(DEAD - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cooler_q, cooler_d;
    logic             heater_q, heater_d;
    logic             active;
    logic             timeout_hit;
    logic             entry_block;

    assign active = (state_q == S_COOL) || (state_q == S_HEAT);

`ifdef HVAC_TIMEOUT_EN
    logic [CNT_W-1:0] run_q, run_d;
    logic             fault_q, fault_d;

    // Run counter sits at zero outside COOL/HEAT, so entry always starts from a clean count.
    always_comb begin
        run_d       = '0;
        timeout_hit = 1'b0;
        if (active) begin
            run_d       = run_q + 1'b1;
            timeout_hit = (run_q == CNT_W'(MAX_RUN - 1));
        end
        fault_d = fault_q | timeout_hit;
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            run_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            run_q   <= run_d;
            fault_q <= fault_d;
        end
    end

    assign entry_block = fault_q;
    assign fault       = fault_q;
`else
    logic unused_max_run;
    assign unused_max_run = (MAX_RUN == 0);
    assign timeout_hit    = 1'b0;
    assign entry_block    = 1'b0;
    assign fault          = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        case (state_q)
            S_OFF: begin
                if (!SFA && !entry_block) begin
                    if (ST > COOL_ON) begin
                        state_d = S_COOL;
                        cnt_d   = MIN_ON_M1;
                    end else if (ST < HEAT_ON) begin
                        state_d = S_HEAT;
                        cnt_d   = MIN_ON_M1;
                    end
                end
            end
            S_COOL: begin
                if (SFA || timeout_hit || ((cnt_q == '0) && (ST <= COOL_OFF))) begin
                    state_d = S_REST;
                    cnt_d   = DEAD_M1;
                end
            end
            S_HEAT: begin
                if (SFA || timeout_hit || ((cnt_q == '0) && (ST >= HEAT_OFF))) begin
                    state_d = S_REST;
                    cnt_d   = DEAD_M1;
                end
            end
            default: begin
                // REST runs its full dead-time regardless of SFA.
                if (cnt_q == '0) begin
                    state_d = S_OFF;
                end
            end
        endcase
        cooler_d = (state_d == S_COOL);
        heater_d = (state_d == S_HEAT);
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q  <= S_OFF;
            cnt_q    <= '0;
            cooler_q <= 1'b0;
            heater_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cooler_q <= cooler_d;
            heater_q <= heater_d;
        end
    end

    assign cooler     = cooler_q;
    assign heater     = heater_q;
    assign hvac_state = state_q;
    assign dwell_busy = (cnt_q != '0);

endmodule

// File: doc/hvac_dwell_controller.md
Name: hvac_dwell_controller

Overview:
- Sequencing controller for the climate actuators of the home automation system.
- Takes the 8-bit temperature sensor ST and the fire-alarm sensor SFA.
- Drives cooler and heater with hysteresis, minimum on-time, a mandatory dead-time between actuations, and a fire-alarm safety override.
- Replaces the direct threshold decode on cooler/heater; outputs feed the top-level cooler/heater pins.

Parameters:
- COOL_ON, 8'd30: cooler request when ST > COOL_ON.
- COOL_OFF, 8'd27: cooler release allowed when ST <= COOL_OFF.
- HEAT_ON, 8'd18: heater request when ST < HEAT_ON.
- HEAT_OFF, 8'd21: heater release allowed when ST >= HEAT_OFF.
- MIN_ON, 1000: minimum cycles an actuator stays on; must be >= 1.
- DEAD, 500: cycles spent in REST after any actuator turns off; must be >= 1.
- MAX_RUN, 60000: run-time limit in cycles; used only with HVAC_TIMEOUT_EN.
- CNT_W, 16: width of the dwell and run counters; must hold MIN_ON, DEAD and MAX_RUN.
- Legal ordering: HEAT_ON < HEAT_OFF <= COOL_OFF < COOL_ON.

Ports:
- clk  in  1  system clock, rising edge.
- Rst  in  1  reset; synchronous, active-high; highest priority.
- ST  in  8  unsigned temperature sample.
- SFA  in  1  fire-alarm sensor; active-high.
- cooler  out  1  cooler drive; registered.
- heater  out  1  heater drive; registered.
- hvac_state  out  2  current state: OFF=00, COOL=01, HEAT=10, REST=11.
- dwell_busy  out  1  high while the dwell counter is nonzero.
- fault  out  1  sticky run-time fault; constant 0 without HVAC_TIMEOUT_EN.

Behaviour:
- Reset (Rst=1 at an edge): state=OFF, cooler=0, heater=0, dwell counter=0, dwell_busy=0, fault=0, run counter=0. Reset mid-run drops the actuators on that same edge.
- Registered outputs: cooler is high iff state=COOL; heater is high iff state=HEAT. Both update on the same edge as the state register, so inputs sampled at edge k take effect at edge k.
- cooler and heater are never high together. Any change between COOL and HEAT must pass through REST and then OFF.
- OFF:
  - SFA=1: stay in OFF.
  - Else ST > COOL_ON: go to COOL, cnt <= MIN_ON-1.
  - Else ST < HEAT_ON: go to HEAT, cnt <= MIN_ON-1.
  - Otherwise stay in OFF.
  - COOL_ON has priority but cannot overlap HEAT_ON under the legal parameter ordering.
- COOL:
  - SFA=1: go to REST, cnt <= DEAD-1. This overrides the minimum on-time.
  - Else cnt==0 and ST <= COOL_OFF: go to REST, cnt <= DEAD-1.
  - Otherwise stay; cnt decrements and saturates at 0.
  - Result: cooler is high for at least MIN_ON cycles, absent SFA or timeout.
- HEAT: same as COOL, using ST >= HEAT_OFF as the release condition.
- REST: cnt decrements each edge. At an edge where cnt==0, go to OFF. REST lasts exactly DEAD cycles; SFA does not shorten or extend it.
- Minimum actuator-off gap: DEAD+1 cycles (REST plus at least one OFF cycle).
- ST inside a hysteresis band (COOL_OFF < ST <= COOL_ON while in COOL): hold the current state indefinitely.
- dwell_busy = (cnt != 0), decoded from the register.
- The counter never wraps: it decrements only while nonzero.

Optional Feature:
- Macro: HVAC_TIMEOUT_EN.
- When defined:
  - A run counter clears on entry to COOL/HEAT and increments each cycle in COOL/HEAT.
  - At the edge where the run counter == MAX_RUN-1 and the state is still COOL/HEAT, go to REST (cnt <= DEAD-1) and set fault=1.
  - fault is sticky until Rst.
  - While fault=1, OFF never enters COOL or HEAT.
- When undefined: no run counter, fault tied to 0, no forced exit.

Test Plan:
- Reset: Rst=1 for 2 cycles with ST=40, SFA=0 -> cooler=heater=0, hvac_state=00, dwell_busy=0, fault=0. Release Rst -> cooler=1 one edge later.
- Min-on (MIN_ON=4, DEAD=3): ST=35 for one edge, then ST=20 -> cooler high exactly 4 cycles, REST 3 cycles, then OFF.
- Hysteresis: in COOL with counter expired, ST=29 held 50 cycles -> cooler stays 1. ST=27 -> REST at the next edge.
- Override: in HEAT with cnt=2, assert SFA -> state=11 and heater=0 at the next edge. Hold SFA with ST=10 -> remains OFF after REST, no heater.
- Changeover (DEAD=3): COOL exit, then ST=10 -> heater rises no earlier than 4 cycles after cooler falls; cooler and heater never both 1.
- Timeout (HVAC_TIMEOUT_EN, MAX_RUN=8): ST=40 held -> cooler high exactly 8 cycles, then fault=1 and state=REST. Remains OFF with fault=1 until Rst.
